// File: rtl/flit_rr_arbiter_pkg.sv
// Shared constants and types for the flit round-robin arbiter.
// Tail flag sits in the flit MSB.
package flit_rr_arbiter_pkg;

  localparam int FLIT_W   = 10;
  localparam int NUM_REQ  = 4;
  localparam int PTR_W    = 2;
  localparam int TAIL_BIT = FLIT_W - 1;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  typedef logic [FLIT_W-1:0]  flit_t;
  typedef logic [PTR_W-1:0]   ptr_t;
  typedef logic [NUM_REQ-1:0] req_vec_t;

endpackage

// File: rtl/flit_rr_arbiter_if.sv
// Requester-side and buffer-side handshake bundle.
// master is the arbiter view, slave the environment view.
interface flit_rr_arbiter_if;
  import flit_rr_arbiter_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*FLIT_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic [FLIT_W-1:0]         out_data;
  logic                      out_ready;

  modport master (
    input  req_valid,
    input  req_data,
    input  out_ready,
    output req_ready,
    output out_valid,
    output out_data
  );

  modport slave (
    output req_valid,
    output req_data,
    output out_ready,
    input  req_ready,
    input  out_valid,
    input  out_data
  );

endinterface

// File: rtl/flit_rr_arbiter_rr_pick.sv
// Round-robin pick: rotate by rr_ptr, find lowest
// valid, rotate the winner back to an absolute index.
module flit_rr_arbiter_rr_pick
  import flit_rr_arbiter_pkg::*;
(
  input  req_vec_t req_valid,
  input  ptr_t     rr_ptr,
  output ptr_t     sel,
  output logic     any_valid
);

  req_vec_t rot;
  ptr_t     off;

  // rotate so the rr_ptr requester lands at bit 0
  always_comb begin
    rot = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      rot[j] = req_valid[rr_ptr + ptr_t'(j)];
    end
  end

  // lowest set bit of the rotated vector wins
  always_comb begin
    off = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) off = ptr_t'(j);
    end
  end

  assign any_valid = |req_valid;
  assign sel       = rr_ptr + off;

endmodule

// File: rtl/flit_rr_arbiter.sv
// Packet-locked round-robin arbiter in front of a flit buffer.
// One registered output stage; a flit is taken only when it can load.
module flit_rr_arbiter
  import flit_rr_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  flit_rr_arbiter_if.master      bus,
  output ptr_t                   grant_id,
  output logic                   busy
);

  logic  state;
  logic  state_nx;
  ptr_t  rr_ptr;
  ptr_t  sel;
  ptr_t  cand;
  logic  any_valid;
  logic  load;
  logic  elig;
  logic  take;
  logic  tail;
  flit_t take_data;

  flit_rr_arbiter_rr_pick u_pick (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .sel       (sel),
    .any_valid (any_valid)
  );

  assign load = !bus.out_valid | bus.out_ready;
  assign busy = (state == ST_LOCKED);

  // a locked owner is the only candidate; otherwise the rr winner
  always_comb begin
    cand = sel;
    elig = any_valid;
    if (state == ST_LOCKED) begin
      cand = grant_id;
      elig = bus.req_valid[grant_id];
    end
  end

  assign take = elig & load & !reset;

  // select the candidate's flit
  always_comb begin
    take_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cand == ptr_t'(i)) begin
        take_data = bus.req_data[i*FLIT_W +: FLIT_W];
      end
    end
  end

  assign tail = take_data[TAIL_BIT];

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // next state: lock on a head flit, unlock on a tail flit
  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == ST_IDLE):
        if (take & !tail) state_nx = ST_LOCKED;
      (state == ST_LOCKED):
        if (take & tail) state_nx = ST_IDLE;
    endcase
  end

  // req_ready decode: one-hot on the taken requester
  always_comb begin
    bus.req_ready = '0;
    if (take) bus.req_ready[cand] = 1'b1;
  end

  // grant and pointer; pointer advances past the owner on tail
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_id <= '0;
      rr_ptr   <= '0;
    end else if (take) begin
      grant_id <= cand;
      if (tail) rr_ptr <= cand + ptr_t'(1);
    end
  end

  // output register: load on take, empty when drained
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else if (take) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= take_data;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_flit_rr_arbiter.sv
// Directed scoreboard bench for flit_rr_arbiter.
// Sources pop on handshake; monitor checks the out stream.
module tb_flit_rr_arbiter;
  import flit_rr_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  ptr_t grant_id;
  logic busy;

  flit_rr_arbiter_if bus ();

  flit_rr_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  flit_t    src [NUM_REQ][$];
  flit_t    sb [$];
  req_vec_t en;
  int       n_chk = 0;
  int       n_fail = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (k < 60 &&
           !(src[0].size() == 0 && src[1].size() == 0 &&
             src[2].size() == 0 && src[3].size() == 0 &&
             !bus.out_valid)) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", 32'(k >= 60), 0);
  endtask

  // requester sources: pop on handshake, present queue heads
  initial begin : drv
    req_vec_t fire;
    bus.req_valid = '0;
    bus.req_data  = '0;
    forever begin
      @(negedge clk);
      fire = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (fire[i]) void'(src[i].pop_front());
      end
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        bus.req_valid[i] = en[i] && src[i].size() != 0;
        bus.req_data[i*FLIT_W +: FLIT_W] =
          (src[i].size() != 0) ? src[i][0] : '0;
      end
    end
  end

  // monitor: invariants and scoreboard on out handshakes
  initial begin : mon
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("ready_onehot",
            32'($onehot0(bus.req_ready)), 1);
        if (bus.out_valid && !bus.out_ready)
          chk("ready_stall", 32'(bus.req_ready), 0);
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_flit: got %0h expected none",
                     bus.out_data);
          end else begin
            chk("out_flit", 32'(bus.out_data), 32'(sb.pop_front()));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    reset = 1'b1;
    bus.out_ready = 1'b1;
    en = '1;

    // reset with all requesters valid, then rr sweep
    src[0].push_back(10'h200);
    src[0].push_back(10'h200);
    src[1].push_back(10'h201);
    src[2].push_back(10'h202);
    src[3].push_back(10'h203);
    sb.push_back(10'h200);
    sb.push_back(10'h201);
    sb.push_back(10'h202);
    sb.push_back(10'h203);
    sb.push_back(10'h200);
    step();
    step();
    @(negedge clk);
    chk("rst_valid_in", 32'(bus.req_valid), 32'hf);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("first_pick", 32'(bus.req_ready), 1);
    chk("first_lat", 32'(bus.out_valid), 0);
    @(negedge clk);
    chk("lat1_valid", 32'(bus.out_valid), 1);
    chk("lat1_data", 32'(bus.out_data), 32'h200);
    chk("rr_next", 32'(bus.req_ready), 2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("throughput", 32'(bus.out_valid), 1);
    end
    wait_idle();

    // packet lock against a waiting requester
    step();
    src[0].push_back(10'h001);
    src[0].push_back(10'h002);
    src[0].push_back(10'h203);
    sb.push_back(10'h001);
    sb.push_back(10'h002);
    sb.push_back(10'h203);
    sb.push_back(10'h211);
    step();
    src[1].push_back(10'h211);
    @(negedge clk);
    chk("lock_busy_b", 32'(busy), 1);
    chk("lock_ready_b", 32'(bus.req_ready), 1);
    @(negedge clk);
    chk("lock_busy_c", 32'(busy), 1);
    chk("lock_ready_c", 32'(bus.req_ready), 1);
    @(negedge clk);
    chk("unlock_busy", 32'(busy), 0);
    chk("unlock_ready", 32'(bus.req_ready), 2);
    wait_idle();

    // output backpressure for 3 cycles
    step();
    src[2].push_back(10'h041);
    src[2].push_back(10'h042);
    src[2].push_back(10'h243);
    sb.push_back(10'h041);
    sb.push_back(10'h042);
    sb.push_back(10'h243);
    step();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus.out_valid), 1);
      chk("stall_data", 32'(bus.out_data), 32'h041);
      chk("stall_ready", 32'(bus.req_ready), 0);
    end
    step();
    bus.out_ready = 1'b1;
    wait_idle();

    // locked owner bubbles while another waits
    step();
    src[2].push_back(10'h051);
    src[2].push_back(10'h052);
    src[2].push_back(10'h253);
    sb.push_back(10'h051);
    sb.push_back(10'h052);
    sb.push_back(10'h253);
    sb.push_back(10'h261);
    step();
    en[2] = 1'b0;
    src[3].push_back(10'h261);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("hold_ready", 32'(bus.req_ready), 0);
      chk("hold_grant", 32'(grant_id), 2);
      chk("hold_busy", 32'(busy), 1);
    end
    step();
    en[2] = 1'b1;
    @(negedge clk);
    chk("resume_m", 32'(bus.req_ready), 4);
    @(negedge clk);
    chk("resume_tail", 32'(bus.req_ready), 4);
    @(negedge clk);
    chk("after_lock", 32'(bus.req_ready), 8);
    wait_idle();

    // reset while locked with a pending output flit
    step();
    src[1].push_back(10'h221);
    src[1].push_back(10'h022);
    sb.push_back(10'h221);
    @(negedge clk);
    step();
    @(negedge clk);
    step();
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("pre_valid", 32'(bus.out_valid), 1);
    chk("pre_data", 32'(bus.out_data), 32'h022);
    chk("pre_busy", 32'(busy), 1);
    chk("pre_grant", 32'(grant_id), 1);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 32'(bus.req_ready), 0);
    step();
    @(negedge clk);
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_grant", 32'(grant_id), 0);
    step();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    src[0].push_back(10'h2a0);
    src[3].push_back(10'h2a3);
    sb.push_back(10'h2a0);
    sb.push_back(10'h2a3);
    @(negedge clk);
    chk("rst_rr_ptr", 32'(bus.req_ready), 1);
    wait_idle();

    chk("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
